// File: rtl/game_session_ctl.sv
// Multi-round two-player session controller: sequences start/play/result screens,
// exchanges status and score over the UART byte, and accumulates totals and round wins.
module game_session_ctl #(
    parameter int ROUNDS         = 3,
    parameter int SCORE_WIDTH    = 9,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int WIN_MODE       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_click,
    input  logic                         round_done,
    input  logic [6:0]                   my_round_score,
    input  logic [7:0]                   uart_data_in,
    output logic [7:0]                   uart_data_out,
    output logic                         start_screen_enable,
    output logic                         game_enable,
    output logic                         game_enable_posedge,
    output logic                         game_end_enable,
    output logic [$clog2(ROUNDS+1)-1:0]  round_idx,
    output logic [SCORE_WIDTH-1:0]       my_total,
    output logic [SCORE_WIDTH-1:0]       enemy_total,
    output logic [$clog2(ROUNDS+1)-1:0]  my_rounds_won,
    output logic [$clog2(ROUNDS+1)-1:0]  enemy_rounds_won,
    output logic [1:0]                   winner_status,
    output logic                         timeout
);
    localparam int RW   = $clog2(ROUNDS + 1);
    localparam int SW   = SCORE_WIDTH;
    localparam int SMAX = (1 << SW) - 1;
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TO_LOAD = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_START, S_WAIT_START, S_PLAY, S_WAIT_END, S_ROUND_RESULT, S_FINAL
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [SW-1:0]   my_round_q, my_round_d, enemy_round_q, enemy_round_d;
    logic [SW-1:0]   my_total_q, my_total_d, enemy_total_q, enemy_total_d;
    logic [RW-1:0]   round_idx_q, round_idx_d, my_wins_q, my_wins_d, enemy_wins_q, enemy_wins_d;
    logic [5:0]      score6_q, score6_d;
    logic            start_flag_q, start_flag_d, ended_flag_q, ended_flag_d;
    logic            sse_q, sse_d, ge_q, ge_d, gep_q, gep_d, gee_q, gee_d, timeout_q, timeout_d;
    logic [1:0]      winner_q, winner_d;

    logic            enemy_start, enemy_ended;
    logic [5:0]      enemy_score;
    assign enemy_start = uart_data_in[7];
    assign enemy_ended = uart_data_in[6];
    assign enemy_score = uart_data_in[5:0];

    function automatic logic [SW-1:0] clamp(input int v);
        if (v > SMAX) return SW'(SMAX);
        return SW'(v);
    endfunction

    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SW] ? {SW{1'b1}} : s[SW-1:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        my_round_d    = my_round_q;
        enemy_round_d = enemy_round_q;
        my_total_d    = my_total_q;
        enemy_total_d = enemy_total_q;
        round_idx_d   = round_idx_q;
        my_wins_d     = my_wins_q;
        enemy_wins_d  = enemy_wins_q;
        score6_d      = score6_q;
        timeout_d     = 1'b0;
        winner_d      = 2'b00;

        case (state_q)
            S_START: if (start_click) state_d = S_WAIT_START;
            S_WAIT_START: begin
                if (enemy_start && !enemy_ended) begin
                    state_d = S_PLAY;
                end else if (TO_EN && wait_cnt_q == '0) begin
                    state_d   = S_START;
                    timeout_d = 1'b1;
                end else if (TO_EN) begin
                    wait_cnt_d = wait_cnt_q - TW'(1);
                end
            end
            S_PLAY: if (round_done) begin
                score6_d   = (my_round_score > 7'd63) ? 6'd63 : my_round_score[5:0];
                my_round_d = clamp(int'(my_round_score));
                state_d    = S_WAIT_END;
            end
            S_WAIT_END: if (enemy_ended) begin
                enemy_round_d = clamp(int'(enemy_score));
                state_d       = S_ROUND_RESULT;
            end
            S_ROUND_RESULT: begin
                my_total_d    = sat_add(my_total_q, my_round_q);
                enemy_total_d = sat_add(enemy_total_q, enemy_round_q);
                if (my_round_q > enemy_round_q) my_wins_d = my_wins_q + RW'(1);
                else if (enemy_round_q > my_round_q) enemy_wins_d = enemy_wins_q + RW'(1);
                if (round_idx_q == RW'(ROUNDS - 1)) begin
                    state_d = S_FINAL;
                end else begin
                    round_idx_d = round_idx_q + RW'(1);
                    state_d     = S_WAIT_START;
                end
            end
            S_FINAL: if (start_click) state_d = S_START;
            default: state_d = S_START;
        endcase

        // the timeout counter is reloaded on every WAIT_START entry
        if (state_q != S_WAIT_START) wait_cnt_d = TO_LOAD;

        if (state_d == S_START) begin
            my_round_d    = '0;
            enemy_round_d = '0;
            my_total_d    = '0;
            enemy_total_d = '0;
            round_idx_d   = '0;
            my_wins_d     = '0;
            enemy_wins_d  = '0;
            score6_d      = '0;
        end

        if (state_d == S_FINAL) begin
            if (WIN_MODE == 1 && my_wins_d != enemy_wins_d)
                winner_d = (my_wins_d > enemy_wins_d) ? 2'b01 : 2'b10;
            else if (my_total_d != enemy_total_d)
                winner_d = (my_total_d > enemy_total_d) ? 2'b01 : 2'b10;
        end

        sse_d        = (state_d == S_START);
        ge_d         = (state_d == S_PLAY);
        gep_d        = (state_d == S_PLAY) && (state_q != S_PLAY);
        gee_d        = (state_d == S_FINAL);
        start_flag_d = (state_d == S_WAIT_START) || (state_d == S_PLAY);
        ended_flag_d = (state_d == S_WAIT_END) || (state_d == S_ROUND_RESULT) || (state_d == S_FINAL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_START;
            wait_cnt_q    <= TO_LOAD;
            my_round_q    <= '0;
            enemy_round_q <= '0;
            my_total_q    <= '0;
            enemy_total_q <= '0;
            round_idx_q   <= '0;
            my_wins_q     <= '0;
            enemy_wins_q  <= '0;
            score6_q      <= '0;
            start_flag_q  <= 1'b0;
            ended_flag_q  <= 1'b0;
            sse_q         <= 1'b1;
            ge_q          <= 1'b0;
            gep_q         <= 1'b0;
            gee_q         <= 1'b0;
            timeout_q     <= 1'b0;
            winner_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            my_round_q    <= my_round_d;
            enemy_round_q <= enemy_round_d;
            my_total_q    <= my_total_d;
            enemy_total_q <= enemy_total_d;
            round_idx_q   <= round_idx_d;
            my_wins_q     <= my_wins_d;
            enemy_wins_q  <= enemy_wins_d;
            score6_q      <= score6_d;
            start_flag_q  <= start_flag_d;
            ended_flag_q  <= ended_flag_d;
            sse_q         <= sse_d;
            ge_q          <= ge_d;
            gep_q         <= gep_d;
            gee_q         <= gee_d;
            timeout_q     <= timeout_d;
            winner_q      <= winner_d;
        end
    end

    assign uart_data_out       = {start_flag_q, ended_flag_q, score6_q};
    assign start_screen_enable = sse_q;
    assign game_enable         = ge_q;
    assign game_enable_posedge = gep_q;
    assign game_end_enable     = gee_q;
    assign round_idx           = round_idx_q;
    assign my_total            = my_total_q;
    assign enemy_total         = enemy_total_q;
    assign my_rounds_won       = my_wins_q;
    assign enemy_rounds_won    = enemy_wins_q;
    assign winner_status       = winner_q;
    assign timeout             = timeout_q;
endmodule
